rggen_indirect_register_handshake: RTL
======================================

// Module: rggen_indirect_register_handshake
// PURPOSE
// - Indirect register with N index fields and a handshaked, wait-state-capable bit-field access path.
// - Decodes its offset and compares INDEX_ENTRIES index inputs against fixed values. On a hit it runs a request/ready handshake with the bit fields.
// - A timeout counter bounds each access. Sits between rggen_register_if (bus side) and rggen_bit_field_if (field side) in generated register blocks.
// PARAMETERS
// READABLE        1     read access allowed
// WRITABLE        1     write access allowed
// ADDRESS_WIDTH   8     bus address width
// OFFSET_ADDRESS  '0    byte offset of the register
// BUS_WIDTH       32    bus data width; power of 2, >=8
// DATA_WIDTH      BUS_WIDTH  register width; integer multiple of BUS_WIDTH
// VALID_BITS      '1    mask of implemented bits, DATA_WIDTH wide
// INDEX_ENTRIES   1     number of index fields compared; >=1
// INDEX_WIDTH     1     width of each index field
// INDEX_VALUES    '0    [INDEX_ENTRIES][INDEX_WIDTH] required index values
// TIMEOUT_CYCLES  0     max cycles in ACCESS before error; 0 = no timeout
// PORTS
// i_clk             in   1                          clock
// i_rst_n           in   1                          async active-low reset
// register_if       if   rggen_register_if.register  bus-side access and response
// i_indirect_index  in   INDEX_ENTRIES*INDEX_WIDTH   current index field values, entry 0 in LSBs
// bit_field_if      if   rggen_bit_field_if.register field-side valid/mask/write_data/read_data
// i_bit_field_ready in   1                          field side completed the pending access
// i_bit_field_error in   1                          field side failure; sampled with ready
// BEHAVIOUR
// - One clock; reset is asynchronous, active-low. Clock i_clk, reset i_rst_n.
// - Hit condition (combinational, IDLE only):
//   - bus valid;
//   - address in [OFFSET_ADDRESS, OFFSET_ADDRESS + DATA_WIDTH/8), compared on the word-aligned address;
//   - every index entry equals INDEX_VALUES;
//   - access type permitted (read needs READABLE, write needs WRITABLE).
// - active output = hit condition. No hit -> active=0; the block stays in IDLE and the external decoder returns the error.
// - FSM IDLE -> ACCESS -> RESP -> IDLE.
//   - IDLE: on hit, capture access, word select, write_data and strobe-expanded mask (VALID_BITS applied); go ACCESS.
//   - ACCESS: drive bit_field read_valid/write_valid=1, held until i_bit_field_ready=1. On ready, capture read_data (masked by VALID_BITS and word-selected) and error; go RESP.
//   - ACCESS timeout: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES without ready, drop valid, set read_data=0 and status=SLVERR; go RESP.
//   - RESP: register_if.ready=1 for exactly one cycle with status OKAY, or SLVERR if error/timeout; go IDLE.
//   - Ready and timeout in the same cycle: ready wins (OKAY/error per input).
// - Latency: the earliest response is 2 cycles after acceptance (ready in the first ACCESS cycle).
// - Bus and index changes after acceptance are ignored; captured values are used.
// - register_if.value always presents the full DATA_WIDTH bit-field value, masked by VALID_BITS.
// - The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits. It clears on entry to ACCESS and saturates.
// - Reset values: state=IDLE, counter=0, ready=0, status=OKAY, read_data=0. Bit-field valid=0, mask=0, write_data=0.
// - Reset mid-access: immediate return to IDLE. No response is issued and the pending field access is abandoned.
// - i_bit_field_ready outside ACCESS is ignored.
// STRUCTURE
// - rggen_rtl_pkg: rggen_access (READ/WRITE), rggen_status (OKAY/SLVERR).
// - rggen_rtl_pkg also holds a new typedef rggen_indirect_state_e {IDLE, ACCESS, RESP}.
// - Sub-module rggen_indirect_index_matcher: parameterised N-entry equality compare, combinational.
// - Address decode, FSM, timeout counter and data steering stay in this module.
// TESTING
// - Index hit, read: INDEX_ENTRIES=2, values {3,5}; index {3,5}; read at OFFSET; field ready after 3 cycles with 0xA5A5_0F0F -> active=1, read_data=0xA5A5_0F0F, OKAY, ready 1 cycle.
// - Index miss: index {3,4} -> active=0, no bit-field valid, FSM stays IDLE.
// - Write masking: DATA_WIDTH=64, BUS_WIDTH=32; write upper word 0xDEAD_BEEF, strobe 4'b0011 -> mask=0x0000_FFFF_0000_0000, write_data carries 0xBEEF in bits [47:32].
// - Timeout: TIMEOUT_CYCLES=4, ready never asserted -> valid drops after 4 ACCESS cycles, SLVERR, read_data=0.
// - Race, then ignored inputs: ready in the timeout cycle -> OKAY. Index changed to a miss during ACCESS -> access still completes OKAY.
// - Reset mid-ACCESS: assert i_rst_n=0 for 1 cycle -> outputs at reset values, no ready pulse, next access works normally.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register blocks: bus access kind, response
// status and the indirect-register handshake state.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY   = 2'b00,
    RGGEN_SLVERR = 2'b10
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } rggen_indirect_state_e;

endpackage

// File: rtl/rggen_indirect_index_matcher.sv
// Combinational equality compare of ENTRIES packed index fields against
// fixed values; entry 0 occupies the LSBs.
module rggen_indirect_index_matcher #(
  parameter int unsigned                   ENTRIES = 1,
  parameter int unsigned                   WIDTH   = 1,
  parameter logic [ENTRIES*WIDTH-1:0]      VALUES  = '0
) (
  input  logic [ENTRIES*WIDTH-1:0] i_index,
  output logic                     o_match
);

  always_comb begin
    o_match = 1'b1;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (i_index[i*WIDTH+:WIDTH] != VALUES[i*WIDTH+:WIDTH]) begin
        o_match = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rggen_indirect_register_handshake.sv
// Indirect register: offset + index decode, then a valid/ready handshake with
// the bit fields bounded by an optional timeout, answered with a one-cycle response.
module rggen_indirect_register_handshake
  import rggen_rtl_pkg::*;
#(
  parameter bit                                    READABLE       = 1'b1,
  parameter bit                                    WRITABLE       = 1'b1,
  parameter int unsigned                           ADDRESS_WIDTH  = 8,
  parameter logic [ADDRESS_WIDTH-1:0]              OFFSET_ADDRESS = '0,
  parameter int unsigned                           BUS_WIDTH      = 32,
  parameter int unsigned                           DATA_WIDTH     = BUS_WIDTH,
  parameter logic [DATA_WIDTH-1:0]                 VALID_BITS     = '1,
  parameter int unsigned                           INDEX_ENTRIES  = 1,
  parameter int unsigned                           INDEX_WIDTH    = 1,
  parameter logic [INDEX_ENTRIES*INDEX_WIDTH-1:0]  INDEX_VALUES   = '0,
  parameter int unsigned                           TIMEOUT_CYCLES = 0
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_register_valid,
  input  logic                                   i_register_access,
  input  logic [ADDRESS_WIDTH-1:0]               i_register_address,
  input  logic [BUS_WIDTH-1:0]                   i_register_write_data,
  input  logic [BUS_WIDTH/8-1:0]                 i_register_strobe,
  output logic                                   o_register_active,
  output logic                                   o_register_ready,
  output logic [1:0]                             o_register_status,
  output logic [BUS_WIDTH-1:0]                   o_register_read_data,
  output logic [DATA_WIDTH-1:0]                  o_register_value,
  input  logic [INDEX_ENTRIES*INDEX_WIDTH-1:0]   i_indirect_index,
  output logic                                   o_bit_field_read_valid,
  output logic                                   o_bit_field_write_valid,
  output logic [DATA_WIDTH-1:0]                  o_bit_field_mask,
  output logic [DATA_WIDTH-1:0]                  o_bit_field_write_data,
  input  logic [DATA_WIDTH-1:0]                  i_bit_field_read_data,
  input  logic [DATA_WIDTH-1:0]                  i_bit_field_value,
  input  logic                                   i_bit_field_ready,
  input  logic                                   i_bit_field_error
);

  localparam int unsigned BUS_BYTES  = BUS_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(BUS_BYTES);
  localparam int unsigned WORDS      = DATA_WIDTH / BUS_WIDTH;
  localparam int unsigned WSW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ADDRESS_WIDTH:0]   START = {1'b0, OFFSET_ADDRESS};
  localparam logic [ADDRESS_WIDTH:0]   LIMIT = START + (ADDRESS_WIDTH+1)'(DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN = ~ADDRESS_WIDTH'(BUS_BYTES - 1);

  rggen_indirect_state_e   state_q, state_d;
  rggen_access             access_q;
  rggen_status             status_q;
  logic [WSW-1:0]          word_sel_q;
  logic [CW-1:0]           count_q;
  logic [BUS_WIDTH-1:0]    read_data_q;
  logic [DATA_WIDTH-1:0]   mask_q;
  logic [DATA_WIDTH-1:0]   write_data_q;

  logic                    index_match;
  logic                    in_range;
  logic                    permitted;
  logic                    hit;
  logic                    timeout;
  logic [ADDRESS_WIDTH:0]  aligned;
  logic [ADDRESS_WIDTH:0]  rel;
  logic [WSW-1:0]          word_sel;
  logic [BUS_WIDTH-1:0]    bus_mask;
  logic [BUS_WIDTH-1:0]    field_word;

  rggen_indirect_index_matcher #(
    .ENTRIES (INDEX_ENTRIES),
    .WIDTH   (INDEX_WIDTH),
    .VALUES  (INDEX_VALUES)
  ) u_index_matcher (
    .i_index (i_indirect_index),
    .o_match (index_match)
  );

  always_comb begin
    aligned   = {1'b0, i_register_address & ALIGN};
    in_range  = (aligned >= START) && (aligned < LIMIT);
    rel       = aligned - START;
    word_sel  = WSW'(rel >> BYTE_SHIFT);
    permitted = (i_register_access == RGGEN_WRITE) ? WRITABLE : READABLE;
    hit       = i_register_valid && (state_q == IDLE) && in_range && index_match && permitted;
    for (int unsigned i = 0; i < BUS_BYTES; i++) begin
      bus_mask[8*i+:8] = {8{i_register_strobe[i]}};
    end
    field_word = BUS_WIDTH'((i_bit_field_read_data & VALID_BITS) >> (int'(word_sel_q) * BUS_WIDTH));
    // count_q only advances on cycles without ready, so count_q + 1 is the ACCESS cycle number
    timeout    = (TIMEOUT_CYCLES > 0) && (CW'(count_q + 1'b1) == CW'(TIMEOUT_CYCLES));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ACCESS;
      ACCESS:  if (i_bit_field_ready || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      access_q     <= RGGEN_READ;
      status_q     <= RGGEN_OKAY;
      word_sel_q   <= '0;
      count_q      <= '0;
      read_data_q  <= '0;
      mask_q       <= '0;
      write_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (hit) begin
        access_q     <= rggen_access'(i_register_access);
        word_sel_q   <= word_sel;
        count_q      <= '0;
        mask_q       <= (DATA_WIDTH'(bus_mask) << (int'(word_sel) * BUS_WIDTH)) & VALID_BITS;
        write_data_q <= DATA_WIDTH'(i_register_write_data) << (int'(word_sel) * BUS_WIDTH);
      end else if (state_q == ACCESS) begin
        if (i_bit_field_ready) begin
          read_data_q <= field_word;
          status_q    <= i_bit_field_error ? RGGEN_SLVERR : RGGEN_OKAY;
        end else if (timeout) begin
          read_data_q <= '0;
          status_q    <= RGGEN_SLVERR;
        end else if (count_q != '1) begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_register_active       = hit;
    o_register_ready        = (state_q == RESP);
    o_register_status       = status_q;
    o_register_read_data    = read_data_q;
    o_register_value        = i_bit_field_value & VALID_BITS;
    o_bit_field_read_valid  = (state_q == ACCESS) && (access_q == RGGEN_READ);
    o_bit_field_write_valid = (state_q == ACCESS) && (access_q == RGGEN_WRITE);
    o_bit_field_mask        = mask_q;
    o_bit_field_write_data  = write_data_q;
  end

endmodule
